memory_responder: RTL and testbench

- Target-side responder for the memory bus driven by the chipset/BIOS loader and, after hand-off, by the CPU.
- Accepts read and write commands on mem_ctrl_bus, mem_addr_bus and mem_write_bus, and returns registered read data on mem_read_bus.
- After reset it clears its storage array to zero, one word per cycle. It holds mem_ready low until the clear completes, so the loader never writes into a half-cleared array.

---
 rtl/memory_responder_pkg.sv | 28 ++
 rtl/memory_responder_ram.sv | 30 +++
 rtl/memory_responder.sv | 124 ++++++++++++
 tb/tb_memory_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the memory responder and its bus agents.
`ifndef MEMSIZE
`define MEMSIZE 256
`endif

package memory_responder_pkg;

  // Default word type used on the data buses.
  typedef logic [7:0] DEFAULT_TYPE;

  // Command codes on mem_ctrl_bus; 2'b11 is reserved and rejected.
  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } MEMORY_FLAG_TYPE;

  localparam logic [1:0] MEM_RESERVED = 2'b11;

  // Responder sequencing: zero-fill the array, then serve commands.
  typedef enum logic {
    RS_CLEAR = 1'b0,
    RS_IDLE  = 1'b1
  } RESP_STATE_TYPE;

  localparam int MEMSIZE = `MEMSIZE;

endpackage

// File: rtl/memory_responder_ram.sv
// Single-port synchronous storage array with registered read data.
// Only one access per cycle; the write takes priority over the read.
module responder_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = "block", RAM_STYLE = "BLOCK" *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write or registered read, one access per cycle.
  // NOTE: no reset here -- a block RAM cannot be reset in one cycle, so the
  // controller zeroes it word by word instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Target-side memory responder: zero-fills its array after reset, then
// serves READ/WRITE commands with one-cycle read latency and flags
// rejected commands on mem_err.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH     = $bits(DEFAULT_TYPE),
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_SIZE       = MEMSIZE,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [1:0]            mem_ctrl_bus,
  input  logic [ADDR_WIDTH-1:0] mem_addr_bus,
  input  logic [DATA_WIDTH-1:0] mem_write_bus,
  output logic [DATA_WIDTH-1:0] mem_read_bus,
  output logic                  mem_valid,
  output logic                  mem_ready,
  output logic                  mem_err
);

  // Index width actually needed by the array; the bus may be wider.
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  // Widened constants so the compares never wrap at MEM_SIZE = 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] SIZE_W    = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(MEM_SIZE - 1);

  RESP_STATE_TYPE        state;
  logic [ADDR_WIDTH:0]   clear_ptr;
  logic                  zero_q;

  logic                  clearing;
  logic                  in_range;
  logic                  rd_cmd;
  logic                  wr_cmd;
  logic                  rsv_cmd;

  logic                  ram_we;
  logic                  ram_re;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign clearing = (state == RS_CLEAR);
  assign in_range = ({1'b0, mem_addr_bus} < SIZE_W);

  // Commands are only decoded once the array is ready; during the clear
  // they are dropped without any response.
  assign rd_cmd  = !clearing && (mem_ctrl_bus == MEM_READ);
  assign wr_cmd  = !clearing && (mem_ctrl_bus == MEM_WRITE);
  assign rsv_cmd = !clearing && (mem_ctrl_bus == MEM_RESERVED);

  // Array port sharing: the clear sequencer owns the port while clearing.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned and a latch cannot be inferred.
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = mem_addr_bus[IDX_W-1:0];
    ram_wdata = mem_write_bus;
    if (clearing) begin
      ram_we    = (CLEAR_ON_RESET != 0);
      ram_addr  = clear_ptr[IDX_W-1:0];
      ram_wdata = '0;
    end else begin
      ram_we = wr_cmd && in_range;
      ram_re = rd_cmd && in_range;
    end
  end

  // Clear sequencer: one zero word per cycle, then hand over to IDLE.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= RS_CLEAR;
      clear_ptr <= '0;
      mem_ready <= 1'b0;
    end else if (clearing) begin
      if (CLEAR_ON_RESET == 0 || clear_ptr == LAST_ADDR) begin
        state     <= RS_IDLE;
        mem_ready <= 1'b1;
      end else begin
        clear_ptr <= clear_ptr + 1'b1;
      end
    end
  end

  // Response flags: valid marks accepted reads, err marks rejected commands,
  // zero_q forces the read bus to zero after reset or an out-of-range read.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mem_valid <= 1'b0;
      mem_err   <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      mem_valid <= rd_cmd;
      mem_err   <= ((rd_cmd || wr_cmd) && !in_range) || rsv_cmd;
      if (rd_cmd) begin
        zero_q <= !in_range;
      end
    end
  end

  // The array's registered output only moves on a read, so the bus holds
  // its value between reads.
  assign mem_read_bus = zero_q ? '0 : ram_rdata;

  responder_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (IDX_W),
    .DEPTH      (MEM_SIZE)
  ) u_ram (
    .clk   (CLOCK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder with a 16-word array.
module tb_memory_responder;
  import memory_responder_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int MS = 16;

  logic          CLOCK;
  logic          RESET;
  logic [1:0]    mem_ctrl_bus;
  logic [AW-1:0] mem_addr_bus;
  logic [DW-1:0] mem_write_bus;
  logic [DW-1:0] mem_read_bus;
  logic          mem_valid;
  logic          mem_ready;
  logic          mem_err;

  int checks   = 0;
  int failures = 0;

  memory_responder #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MEM_SIZE       (MS),
    .CLEAR_ON_RESET (1)
  ) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .mem_ctrl_bus  (mem_ctrl_bus),
    .mem_addr_bus  (mem_addr_bus),
    .mem_write_bus (mem_write_bus),
    .mem_read_bus  (mem_read_bus),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_err       (mem_err)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command at a falling edge; it is sampled on the next rising
  // edge and the result is visible when this task returns at the next
  // falling edge.
  task automatic issue(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_ctrl_bus  = c;
    mem_addr_bus  = a;
    mem_write_bus = d;
    @(negedge CLOCK);
    mem_ctrl_bus  = MEM_NONE;
  endtask

  // Release reset at a falling edge and count edges until mem_ready, while
  // hammering a WRITE that must be ignored.
  task automatic release_and_count(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    logic seen_err;
    logic seen_valid;
    n          = 0;
    seen_err   = 1'b0;
    seen_valid = 1'b0;
    RESET      = 1'b0;
    mem_ctrl_bus  = MEM_WRITE;
    mem_addr_bus  = a;
    mem_write_bus = d;
    while (!mem_ready && n < 200) begin
      @(negedge CLOCK);
      n++;
      seen_err   = seen_err | mem_err;
      seen_valid = seen_valid | mem_valid;
    end
    mem_ctrl_bus = MEM_NONE;
    check({tag, "_cycles"}, n, MS);
    check({tag, "_no_err"}, seen_err, 1'b0);
    check({tag, "_no_valid"}, seen_valid, 1'b0);
  endtask

  task automatic expect_read(input string tag, input logic [DW-1:0] data, input logic err);
    check({tag, "_data"}, mem_read_bus, data);
    check({tag, "_valid"}, mem_valid, 1'b1);
    check({tag, "_err"}, mem_err, err);
  endtask

  initial begin
    logic [DW-1:0] wvals [3];
    wvals[0] = 8'h11;
    wvals[1] = 8'h22;
    wvals[2] = 8'h33;

    RESET         = 1'b1;
    mem_ctrl_bus  = MEM_NONE;
    mem_addr_bus  = '0;
    mem_write_bus = '0;
    repeat (3) @(negedge CLOCK);
    check("rst_data", mem_read_bus, 8'h00);
    check("rst_valid", mem_valid, 1'b0);
    check("rst_ready", mem_ready, 1'b0);
    check("rst_err", mem_err, 1'b0);

    // Clear after reset; a WRITE to 0x03 during the clear must be ignored.
    release_and_count("clear1", 8'h03, 8'h5A);

    // Every word reads back zero, one valid pulse each.
    for (int i = 0; i < MS; i++) begin
      issue(MEM_READ, AW'(i), 8'h00);
      expect_read($sformatf("zero_rd%0d", i), 8'h00, 1'b0);
    end
    issue(MEM_NONE, 8'h00, 8'h00);
    check("idle_valid_low", mem_valid, 1'b0);

    // Write then read the same address on the next cycle.
    issue(MEM_WRITE, 8'h05, 8'hA7);
    check("wr5_valid", mem_valid, 1'b0);
    check("wr5_err", mem_err, 1'b0);
    issue(MEM_READ, 8'h05, 8'h00);
    expect_read("rd5", 8'hA7, 1'b0);

    // Three writes, then three back-to-back reads.
    for (int i = 0; i < 3; i++) issue(MEM_WRITE, AW'(i + 1), wvals[i]);
    for (int i = 0; i < 3; i++) begin
      issue(MEM_READ, AW'(i + 1), 8'h00);
      expect_read($sformatf("b2b%0d", i), wvals[i], 1'b0);
    end
    issue(MEM_NONE, 8'h00, 8'h00);
    check("hold_data", mem_read_bus, 8'h33);
    check("hold_valid", mem_valid, 1'b0);

    // Out-of-range write is dropped and flagged.
    issue(MEM_WRITE, 8'h20, 8'hFF);
    check("oor_wr_err", mem_err, 1'b1);
    check("oor_wr_valid", mem_valid, 1'b0);
    issue(MEM_NONE, 8'h00, 8'h00);
    check("err_pulse_end", mem_err, 1'b0);
    issue(MEM_READ, 8'h20, 8'h00);
    expect_read("oor_rd", 8'h00, 1'b1);
    issue(MEM_READ, 8'h00, 8'h00);
    expect_read("alias_rd0", 8'h00, 1'b0);
    issue(MEM_READ, 8'h05, 8'h00);
    expect_read("rd5_again", 8'hA7, 1'b0);
    issue(MEM_RESERVED, 8'h05, 8'h00);
    check("rsv_err", mem_err, 1'b1);
    check("rsv_valid", mem_valid, 1'b0);
    check("rsv_hold", mem_read_bus, 8'hA7);

    // Asynchronous reset while read data is being presented.
    issue(MEM_READ, 8'h05, 8'h00);
    expect_read("pre_rst_rd", 8'hA7, 1'b0);
    #2 RESET = 1'b1;
    #1;
    check("async_rd_data", mem_read_bus, 8'h00);
    check("async_rd_valid", mem_valid, 1'b0);
    check("async_rd_ready", mem_ready, 1'b0);
    @(negedge CLOCK);
    RESET = 1'b0;

    // Let the clear reach clear_ptr=7, then reset again between edges.
    repeat (7) @(negedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    check("async_clr_data", mem_read_bus, 8'h00);
    check("async_clr_valid", mem_valid, 1'b0);
    check("async_clr_ready", mem_ready, 1'b0);
    check("async_clr_err", mem_err, 1'b0);
    @(negedge CLOCK);
    release_and_count("clear2", 8'h07, 8'hC3);

    // The restarted clear zeroed the whole array again.
    issue(MEM_READ, 8'h05, 8'h00);
    expect_read("post_clr_rd5", 8'h00, 1'b0);
    issue(MEM_READ, 8'h07, 8'h00);
    expect_read("post_clr_rd7", 8'h00, 1'b0);
    issue(MEM_READ, 8'h0F, 8'h00);
    expect_read("post_clr_rd15", 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
